// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundles the PC-stage, instruction-memory and decode-side
// signals of the instruction-fetch front end.
//
// Handshake semantics (all three channels):
//   - PC stage : the PC in pc_if_i is consumed on a rising edge where
//                stall_if_o is 0; stall_if_o = 1 means "hold the PC".
//   - Memory   : a request transfers on an edge where imem_req_o & imem_gnt_i;
//                imem_req_o never depends on imem_gnt_i. Responses return in
//                request order on imem_rvalid_i, at least one cycle after grant,
//                with no back-pressure.
//   - Decode   : the head entry transfers on an edge where id_valid_o & id_ready_i;
//                id_valid_o never depends on id_ready_i.
// The master modport is the fetch queue itself; slave is its environment.
interface ifetch_queue_if;
    logic [31:0] pc_if_i;
    logic        flush_if_i;
    logic        stall_if_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_misalign_o;

    modport master (
        input  pc_if_i, flush_if_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        output stall_if_o, imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o,
        id_misalign_o
    );

    modport slave (
        output pc_if_i, flush_if_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        input  stall_if_o, imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o,
        id_misalign_o
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end between the PC stage and decode.
// Issues the presented PC to instruction memory, pairs in-order responses with
// their PCs through an in-flight PC FIFO, and buffers fetched words for decode.
// A credit rule (buffered + outstanding < FIFO_DEPTH) guarantees every response
// has a free buffer slot. Flushes empty the buffer and count the in-flight
// responses that must be discarded when they come back.
//
// Optional feature macro: IFETCH_MISALIGN_CHK_EN
//   defined   : PCs with pc[1:0] != 0 are not sent to memory; once older fetches
//               have drained they are enqueued directly as a NOP flagged misaligned.
//   undefined : every PC is issued unchanged and id_misalign_o is tied 0.
module ifetch_queue #(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] INFL_LAST = IW'(MAX_OUTSTANDING - 1);

    // In-flight PC FIFO (MAX_OUTSTANDING need not be a power of two).
    logic [31:0]   infl_pc [MAX_OUTSTANDING];
    logic [IW-1:0] infl_wr;
    logic [IW-1:0] infl_rd;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    // Instruction buffer towards decode.
    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic [31:0]   buf_pc    [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    logic [CW:0]   credit_used;
    logic          issue_ok;
    logic          grant;
    logic          resp;
    logic          discard;
    logic          push;
    logic          pop;
    logic          mis_enq;
    logic [31:0]   push_instr;
    logic [31:0]   push_pc;

    function automatic logic [IW-1:0] infl_next(input logic [IW-1:0] p);
        return (p == INFL_LAST) ? '0 : p + IW'(1);
    endfunction

    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign issue_ok    = !rst && !bus.flush_if_i && (outstanding < MAX_OUT_C)
                         && (credit_used < DEPTH_C);

`ifdef IFETCH_MISALIGN_CHK_EN
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    logic buf_mis [FIFO_DEPTH];
    logic pc_misaligned;

    assign pc_misaligned  = (bus.pc_if_i[1:0] != 2'b00);
    // Wait for older fetches to return so the NOP lands behind them in order.
    assign mis_enq        = issue_ok && pc_misaligned && (outstanding == '0);
    assign bus.imem_req_o = issue_ok && !pc_misaligned;
    assign push_instr     = mis_enq ? NOP_INSTR : bus.imem_rdata_i;
`else
    assign mis_enq        = 1'b0;
    assign bus.imem_req_o = issue_ok;
    assign push_instr     = bus.imem_rdata_i;
`endif

    assign bus.imem_addr_o = bus.pc_if_i;
    assign grant           = bus.imem_req_o && bus.imem_gnt_i;
    // A response with nothing in flight is spurious and ignored.
    assign resp            = bus.imem_rvalid_i && (outstanding != '0);
    // Responses in the flush cycle, or owed to an earlier flush, are wrong-path.
    assign discard         = bus.flush_if_i || (drop_cnt != '0);
    assign push            = (resp && !discard) || mis_enq;
    assign push_pc         = mis_enq ? bus.pc_if_i : infl_pc[infl_rd];
    assign pop             = bus.id_valid_o && bus.id_ready_i && !bus.flush_if_i;
    // In a flush cycle the PC stage must load the redirect target, so no stall.
    assign bus.stall_if_o  = rst || (!bus.flush_if_i && !grant && !mis_enq);

    assign bus.id_valid_o  = !rst && (fifo_count != '0);
    assign bus.id_instr_o  = bus.id_valid_o ? buf_instr[rd_ptr] : '0;
    assign bus.id_pc_o     = bus.id_valid_o ? buf_pc[rd_ptr] : '0;
`ifdef IFETCH_MISALIGN_CHK_EN
    assign bus.id_misalign_o = bus.id_valid_o ? buf_mis[rd_ptr] : 1'b0;
`else
    assign bus.id_misalign_o = 1'b0;
`endif

    // Track granted-but-unanswered fetches and how many of them are wrong-path.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_wr     <= '0;
            infl_rd     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                infl_pc[i] <= '0;
            end
        end else begin
            if (grant) begin
                infl_pc[infl_wr] <= bus.pc_if_i;
                infl_wr          <= infl_next(infl_wr);
            end
            if (resp) begin
                infl_rd <= infl_next(infl_rd);
            end
            if (grant && !resp) begin
                outstanding <= outstanding + CW'(1);
            end else if (!grant && resp) begin
                outstanding <= outstanding - CW'(1);
            end
            // No grant can happen in a flush cycle, so what remains in flight
            // after this cycle's response is exactly what must be dropped.
            if (bus.flush_if_i) begin
                drop_cnt <= outstanding - CW'(resp);
            end else if (resp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Instruction buffer: push fetched words, pop on decode accept, empty on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
`ifdef IFETCH_MISALIGN_CHK_EN
                buf_mis[i]   <= 1'b0;
`endif
            end
        end else if (bus.flush_if_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= push_instr;
                buf_pc[wr_ptr]    <= push_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
                buf_mis[wr_ptr]   <= mis_enq;
`endif
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Flag memory responses that arrive with nothing in flight.
    rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rvalid_i |-> (outstanding != '0))
        else $error("ifetch_queue: imem_rvalid_i with no outstanding request");

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_ifetch_queue;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ifetch_queue_if bus ();

    ifetch_queue #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0] ^ 16'h0a13};
    endfunction

    // ---------------- environment: PC stage + in-order memory ----------------
    logic [31:0] pc_r;
    logic [31:0] mem_q[$];

    task automatic drive_raw(input logic r, input logic f, input logic [31:0] p,
                             input logic g, input logic rv, input logic [31:0] d,
                             input logic rdy);
        rst               = r;
        bus.flush_if_i    = f;
        bus.pc_if_i       = p;
        bus.imem_gnt_i    = g;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = d;
        bus.id_ready_i    = rdy;
    endtask

    task automatic env_drive(input logic r, input logic f, input logic g,
                             input logic rv_en, input logic rdy);
        logic rv;
        rv = rv_en && (mem_q.size() != 0);
        drive_raw(r, f, pc_r, g, rv, rv ? mem_word(mem_q[0]) : 32'h0, rdy);
    endtask

    task automatic env_advance(input logic [31:0] target);
        if (rst) begin
            mem_q.delete();
        end else begin
            if (bus.imem_rvalid_i && (mem_q.size() != 0)) void'(mem_q.pop_front());
            if (bus.imem_req_o && bus.imem_gnt_i) mem_q.push_back(bus.imem_addr_o);
            if (bus.flush_if_i) pc_r = target;
            else if (!bus.stall_if_o) pc_r = pc_r + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic env_reset(input logic [31:0] start_pc);
        pc_r = start_pc;
        env_drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        env_advance(32'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        r;
        logic        f;
        logic [31:0] pc;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic [31:0] pc,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_stall, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v.r = r; v.f = f; v.pc = pc; v.g = g; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t vecs[15];

    // ---------------- reference model state ----------------
    logic [63:0] exp_q[$];   // buffered entries {pc, instr}
    logic [31:0] infl_q[$];  // PCs granted but not yet answered
    int          drop_n;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pc_r     = 32'h0;
        drive_raw(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        //            r  f  pc     g  rv rdata         rdy  req addr   stl vld instr         pc
        vecs[0]  = mk(1, 0, 32'h0, 0, 0, 32'h0,        1,   0, 32'h0,  1,  0,  32'h0,        32'h0);
        vecs[1]  = mk(0, 0, 32'h0, 1, 0, 32'h0,        1,   1, 32'h0,  0,  0,  32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 32'h4, 1, 1, 32'h00500093, 1,   1, 32'h4,  0,  0,  32'h0,        32'h0);
        vecs[3]  = mk(0, 0, 32'h8, 1, 1, 32'h00100113, 1,   1, 32'h8,  0,  1,  32'h00500093, 32'h0);
        vecs[4]  = mk(0, 0, 32'hc, 1, 1, 32'h00200193, 1,   1, 32'hc,  0,  1,  32'h00100113, 32'h4);
        vecs[5]  = mk(0, 0, 32'h10,0, 1, 32'h00300213, 1,   1, 32'h10, 1,  1,  32'h00200193, 32'h8);
        vecs[6]  = mk(0, 0, 32'h10,0, 0, 32'h0,        1,   1, 32'h10, 1,  1,  32'h00300213, 32'hc);
        vecs[7]  = mk(0, 0, 32'h10,0, 0, 32'h0,        1,   1, 32'h10, 1,  0,  32'h0,        32'h0);
        vecs[8]  = mk(1, 0, 32'h20,0, 0, 32'h0,        1,   0, 32'h20, 1,  0,  32'h0,        32'h0);
        vecs[9]  = mk(0, 0, 32'h20,0, 0, 32'h0,        1,   1, 32'h20, 1,  0,  32'h0,        32'h0);
        vecs[10] = mk(0, 0, 32'h20,0, 0, 32'h0,        1,   1, 32'h20, 1,  0,  32'h0,        32'h0);
        vecs[11] = mk(0, 0, 32'h20,0, 0, 32'h0,        1,   1, 32'h20, 1,  0,  32'h0,        32'h0);
        vecs[12] = mk(0, 0, 32'h20,1, 0, 32'h0,        1,   1, 32'h20, 0,  0,  32'h0,        32'h0);
        vecs[13] = mk(0, 0, 32'h24,0, 1, 32'h00000033, 1,   1, 32'h24, 1,  0,  32'h0,        32'h0);
        vecs[14] = mk(0, 0, 32'h24,0, 0, 32'h0,        1,   1, 32'h24, 1,  1,  32'h00000033, 32'h20);

        @(posedge clk);
        #1;

        // ---- table: first fetches, back-to-back flow, grant held low ----
        for (int i = 0; i < 15; i++) begin
            drive_raw(vecs[i].r, vecs[i].f, vecs[i].pc, vecs[i].g, vecs[i].rv, vecs[i].rd,
                      vecs[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d req", i),   32'(bus.imem_req_o), 32'(vecs[i].e_req));
            check($sformatf("vec%0d addr", i),  bus.imem_addr_o,     vecs[i].e_addr);
            check($sformatf("vec%0d stall", i), 32'(bus.stall_if_o), 32'(vecs[i].e_stall));
            check($sformatf("vec%0d valid", i), 32'(bus.id_valid_o), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d instr", i), bus.id_instr_o,      vecs[i].e_instr);
            check($sformatf("vec%0d pc", i),    bus.id_pc_o,         vecs[i].e_pc);
            @(posedge clk);
            #1;
        end

        // ---- full buffer with decode stalled, then one pop frees one slot ----
        env_reset(32'h0);
        for (int c = 0; c < 5; c++) begin
            env_drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            env_advance(32'h0);
        end
        env_drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("full req",   32'(bus.imem_req_o), 32'd0);
        check("full stall", 32'(bus.stall_if_o), 32'd1);
        check("full head",  bus.id_pc_o,         32'h0);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("pop cycle req", 32'(bus.imem_req_o), 32'd0);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("refill req",   32'(bus.imem_req_o), 32'd1);
        check("refill addr",  bus.imem_addr_o,     32'h10);
        check("refill stall", 32'(bus.stall_if_o), 32'd0);
        env_advance(32'h0);
        for (int c = 0; c < 3; c++) begin
            env_drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("refull%0d req", c), 32'(bus.imem_req_o), 32'd0);
            env_advance(32'h0);
        end
        for (int c = 0; c < 4; c++) begin
            env_drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            check($sformatf("drain%0d valid", c), 32'(bus.id_valid_o), 32'd1);
            check($sformatf("drain%0d pc", c),    bus.id_pc_o,    32'h4 * (c + 1));
            check($sformatf("drain%0d instr", c), bus.id_instr_o, mem_word(32'h4 * (c + 1)));
            env_advance(32'h0);
        end

        // ---- flush with two fetches in flight ----
        env_reset(32'h10);
        env_drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("fl req0", bus.imem_addr_o, 32'h10);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("fl req1", 32'(bus.imem_req_o), 32'd1);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("fl maxout req", 32'(bus.imem_req_o), 32'd0);
        check("fl maxout stall", 32'(bus.stall_if_o), 32'd1);
        env_advance(32'h0);
        env_drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("fl cycle req",   32'(bus.imem_req_o), 32'd0);
        check("fl cycle stall", 32'(bus.stall_if_o), 32'd0);
        env_advance(32'h100);
        env_drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("fl drop0 valid", 32'(bus.id_valid_o), 32'd0);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("fl redirect req",  32'(bus.imem_req_o), 32'd1);
        check("fl redirect addr", bus.imem_addr_o,     32'h100);
        check("fl drop1 valid",   32'(bus.id_valid_o), 32'd0);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("fl wait valid", 32'(bus.id_valid_o), 32'd0);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("fl target valid", 32'(bus.id_valid_o), 32'd1);
        check("fl target pc",    bus.id_pc_o,         32'h100);
        check("fl target instr", bus.id_instr_o,      mem_word(32'h100));
        env_advance(32'h0);

        // ---- flush in the same cycle as a response ----
        env_reset(32'h40);
        for (int c = 0; c < 2; c++) begin
            env_drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            env_advance(32'h0);
        end
        env_drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("flrv rvalid driven", 32'(bus.imem_rvalid_i), 32'd1);
        check("flrv stall", 32'(bus.stall_if_o), 32'd0);
        env_advance(32'h200);
        env_drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("flrv redirect addr", bus.imem_addr_o, 32'h200);
        check("flrv redirect req",  32'(bus.imem_req_o), 32'd1);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("flrv stale valid", 32'(bus.id_valid_o), 32'd0);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("flrv target valid", 32'(bus.id_valid_o), 32'd1);
        check("flrv target pc",    bus.id_pc_o,         32'h200);
        env_advance(32'h0);

`ifdef IFETCH_MISALIGN_CHK_EN
        // ---- misaligned PC becomes a flagged NOP without a memory request ----
        env_reset(32'h22);
        env_drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("mis req",   32'(bus.imem_req_o), 32'd0);
        check("mis stall", 32'(bus.stall_if_o), 32'd0);
        env_advance(32'h0);
        env_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("mis valid", 32'(bus.id_valid_o),    32'd1);
        check("mis instr", bus.id_instr_o,         32'h00000013);
        check("mis flag",  32'(bus.id_misalign_o), 32'd1);
        check("mis pc",    bus.id_pc_o,            32'h22);
        env_advance(32'h0);
`endif

        // ---- randomized run against the queue model ----
        env_reset(32'h1000);
        exp_q.delete();
        infl_q.delete();
        drop_n = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r, f, g, rv_en, rdy, e_req, e_stall, e_valid;
            logic [31:0] tgt, e_instr, e_pc, p;
            r     = ($urandom_range(0, 299) == 0);
            f     = ($urandom_range(0, 19) == 0);
            g     = ($urandom_range(0, 3) != 0);
            rv_en = ($urandom_range(0, 2) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            tgt   = $urandom & 32'h0000_fffc;
            env_drive(r, f, g, rv_en, rdy);

            e_req   = !r && !f && (infl_q.size() < MAXO) && (exp_q.size() + infl_q.size() < DEPTH);
            e_stall = r || (!f && !(e_req && g));
            e_valid = !r && (exp_q.size() != 0);
            e_instr = e_valid ? exp_q[0][31:0] : 32'h0;
            e_pc    = e_valid ? exp_q[0][63:32] : 32'h0;

            @(negedge clk);
            check($sformatf("rnd%0d req", c),   32'(bus.imem_req_o), 32'(e_req));
            check($sformatf("rnd%0d stall", c), 32'(bus.stall_if_o), 32'(e_stall));
            check($sformatf("rnd%0d valid", c), 32'(bus.id_valid_o), 32'(e_valid));
            check($sformatf("rnd%0d instr", c), bus.id_instr_o,      e_instr);
            check($sformatf("rnd%0d pc", c),    bus.id_pc_o,         e_pc);
            check($sformatf("rnd%0d mis", c),   32'(bus.id_misalign_o), 32'd0);
            if (e_req) check($sformatf("rnd%0d addr", c), bus.imem_addr_o, pc_r);

            if (r) begin
                exp_q.delete();
                infl_q.delete();
                drop_n = 0;
            end else begin
                if (e_valid && rdy && !f) void'(exp_q.pop_front());
                if (bus.imem_rvalid_i && (infl_q.size() != 0)) begin
                    p = infl_q.pop_front();
                    if (!f) begin
                        if (drop_n > 0) drop_n--;
                        else exp_q.push_back({p, bus.imem_rdata_i});
                    end
                end
                if (e_req && g) infl_q.push_back(pc_r);
                if (f) begin
                    exp_q.delete();
                    drop_n = infl_q.size();
                end
            end
            env_advance(tgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
